// File: rtl/ysyx_22050039_ifu_fetch.sv
// ysyx_22050039_ifu_fetch: PC, single-outstanding imem fetch, instruction FIFO to decode; YSYX_22050039_IFU_PERF_EN adds perf counters
module ysyx_22050039_ifu_fetch #(
  parameter int XLEN = 64,
  parameter int INST_LEN = 32,
  parameter logic [XLEN-1:0] RESET_PC = 64'h8000_0000,
  parameter int DEPTH = 2
) (
  input  logic                clk,
  input  logic                rst,
  output logic                imem_req_valid,
  input  logic                imem_req_ready,
  output logic [XLEN-1:0]     imem_addr,
  input  logic                imem_rsp_valid,
  input  logic [INST_LEN-1:0] imem_rsp_data,
  output logic                inst_valid,
  input  logic                inst_ready,
  output logic [INST_LEN-1:0] inst,
  output logic [XLEN-1:0]     inst_pc,
`ifdef YSYX_22050039_IFU_PERF_EN
  output logic [31:0]         perf_fetch_cnt,
  output logic [31:0]         perf_drop_cnt,
`endif
  input  logic                redirect_valid,
  input  logic [XLEN-1:0]     redirect_pc
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  typedef enum logic [1:0] {REQ, WAIT, DROP} state_t;
  state_t state, state_n;
  logic [XLEN-1:0] pc, fetch_pc;
  logic [CW-1:0] count;
  logic [PW-1:0] head, tail;
  logic [INST_LEN-1:0] mem_inst [DEPTH];
  logic [XLEN-1:0] mem_pc [DEPTH];
  logic full, req_fire, push, pop, drop;
  assign full = count == CW'(DEPTH);
  assign inst_valid = count != '0;
  assign inst = mem_inst[head];
  assign inst_pc = mem_pc[head];
  assign imem_addr = pc;
  assign req_fire = imem_req_valid && imem_req_ready;
  assign pop = inst_valid && inst_ready && !redirect_valid;
  // request gating, response routing (keep or discard) and next fetch state
  always_comb begin
    imem_req_valid = state == REQ && rst && !full && !redirect_valid;
    push = state == WAIT && imem_rsp_valid && !redirect_valid;
    drop = imem_rsp_valid && (state == DROP || (state == WAIT && redirect_valid));
    state_n = state == REQ ? (req_fire ? WAIT : REQ) :
              state == WAIT ? (imem_rsp_valid ? REQ : redirect_valid ? DROP : WAIT) :
              (imem_rsp_valid ? REQ : DROP);
  end
  // PC, fetch state and FIFO; a redirect flushes the FIFO and cancels any push/pop
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= REQ;
      pc <= RESET_PC;
      fetch_pc <= '0;
      count <= '0;
      head <= '0;
      tail <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_inst[i] <= '0;
        mem_pc[i] <= '0;
      end
    end else begin
      state <= state_n;
      pc <= redirect_valid ? redirect_pc & ~XLEN'(3) : req_fire ? pc + XLEN'(4) : pc;
      if (req_fire) fetch_pc <= pc;
      count <= redirect_valid ? '0 : count + CW'(push) - CW'(pop);
      head <= redirect_valid ? '0 : pop ? head + PW'(1) : head;
      tail <= redirect_valid ? '0 : push ? tail + PW'(1) : tail;
      if (push) begin
        mem_inst[tail] <= imem_rsp_data;
        mem_pc[tail] <= fetch_pc;
      end
    end
  end
`ifdef YSYX_22050039_IFU_PERF_EN
  // counts of buffered and discarded responses, wrapping at 2^32
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      perf_fetch_cnt <= '0;
      perf_drop_cnt <= '0;
    end else begin
      perf_fetch_cnt <= perf_fetch_cnt + 32'(push);
      perf_drop_cnt <= perf_drop_cnt + 32'(drop);
    end
  end
`endif
endmodule

// File: tb/tb_ysyx_22050039_ifu_fetch.sv
// tb_ysyx_22050039_ifu_fetch: randomized and directed bench with a fetch-stream scoreboard
module tb_ysyx_22050039_ifu_fetch;
  localparam logic [63:0] RST_PC = 64'h8000_0000;
  logic clk = 0, rst = 0;
  logic imem_req_valid, imem_req_ready = 0;
  logic [63:0] imem_addr;
  logic imem_rsp_valid = 0;
  logic [31:0] imem_rsp_data = '0;
  logic inst_valid, inst_ready = 0;
  logic [31:0] inst;
  logic [63:0] inst_pc;
  logic redirect_valid = 0;
  logic [63:0] redirect_pc = '0;
`ifdef YSYX_22050039_IFU_PERF_EN
  logic [31:0] perf_fetch_cnt, perf_drop_cnt;
`endif
  int n_cmp = 0, n_fail = 0, n_pop = 0, lat_lo = 1, lat_hi = 1;

  ysyx_22050039_ifu_fetch dut (
    .clk(clk), .rst(rst),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready), .imem_addr(imem_addr),
    .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
    .inst_valid(inst_valid), .inst_ready(inst_ready), .inst(inst), .inst_pc(inst_pc),
`ifdef YSYX_22050039_IFU_PERF_EN
    .perf_fetch_cnt(perf_fetch_cnt), .perf_drop_cnt(perf_drop_cnt),
`endif
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc)
  );

  always #5 clk = ~clk;

  // memory image: every address holds a distinct word; f(0x8000_0000) = 0x00100093
  function automatic logic [31:0] f(input logic [63:0] a);
    return a[31:0] ^ 32'h8010_0093;
  endfunction

  // memory: accepts a request, answers after lat_lo..lat_hi cycles, keeps pending answers across reset
  initial begin : mem
    logic fire, pend;
    logic [63:0] a_s, pa;
    int cd;
    pend = 0; cd = 0; pa = '0;
    forever begin
      @(negedge clk);
      fire = rst && imem_req_valid && imem_req_ready;
      a_s = imem_addr;
      if (fire) begin
        n_cmp++;
        if (pend) begin n_fail++; $display("FAIL one_outstanding: request %h accepted while %h still pending", a_s, pa); end
      end
      @(posedge clk); #1;
      imem_rsp_valid = 0;
      if (fire) begin pend = 1; pa = a_s; cd = $urandom_range(lat_hi, lat_lo); end
      if (pend) begin
        cd--;
        if (cd == 0) begin imem_rsp_valid = 1; imem_rsp_data = f(pa); pend = 0; end
      end
    end
  end

  // scoreboard: requests and delivered instructions must follow pc, pc+4, ... restarting at each redirect target
  initial begin : mon
    logic [63:0] er, ep;
    logic pr;
    er = RST_PC; ep = RST_PC; pr = 0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        er = RST_PC; ep = RST_PC; pr = 0;
      end else begin
        if (pr) begin
          n_cmp++;
          if (inst_valid !== 1'b0) begin n_fail++; $display("FAIL flush_after_redirect: inst_valid=%b required 0", inst_valid); end
        end
        if (redirect_valid) begin
          n_cmp++;
          if (imem_req_valid !== 1'b0) begin n_fail++; $display("FAIL req_during_redirect: imem_req_valid=%b required 0", imem_req_valid); end
          er = redirect_pc & ~64'd3;
          ep = er;
        end else begin
          if (imem_req_valid && imem_req_ready) begin
            n_cmp++;
            if (imem_addr !== er) begin n_fail++; $display("FAIL req_addr: got %h required %h", imem_addr, er); end
            er += 64'd4;
          end
          if (inst_valid && inst_ready) begin
            n_cmp++; n_pop++;
            if (inst_pc !== ep || inst !== f(ep)) begin n_fail++; $display("FAIL pop: got pc %h inst %h required pc %h inst %h", inst_pc, inst, ep, f(ep)); end
            ep += 64'd4;
          end
        end
        pr = redirect_valid;
      end
    end
  end

  initial begin : watchdog
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic wait_fire(input int n, output bit ok);
    ok = 0;
    for (int i = 0; i < n && !ok; i++) begin
      @(negedge clk);
      ok = imem_req_valid && imem_req_ready;
    end
    if (!ok) begin n_cmp++; n_fail++; $display("FAIL fire_timeout: no request accepted within %0d cycles", n); end
  endtask

  task automatic do_reset();
    tick();
    rst = 0; imem_req_ready = 0; inst_ready = 0; redirect_valid = 0; lat_lo = 1; lat_hi = 1;
    repeat (6) tick();
    rst = 1;
  endtask

  task automatic test_reset();
    imem_req_ready = 1;
    @(negedge clk);
    n_cmp++; if (imem_req_valid !== 1'b0) begin n_fail++; $display("FAIL rst_req_valid: got %b required 0", imem_req_valid); end
    n_cmp++; if (imem_addr !== RST_PC) begin n_fail++; $display("FAIL rst_addr: got %h required %h", imem_addr, RST_PC); end
    n_cmp++; if (inst_valid !== 1'b0) begin n_fail++; $display("FAIL rst_inst_valid: got %b required 0", inst_valid); end
    n_cmp++; if (inst !== 32'h0) begin n_fail++; $display("FAIL rst_inst: got %h required 0", inst); end
    n_cmp++; if (inst_pc !== 64'h0) begin n_fail++; $display("FAIL rst_inst_pc: got %h required 0", inst_pc); end
  endtask

  task automatic test_basic();
    bit ok;
    do_reset();
    imem_req_ready = 1; inst_ready = 1;
    wait_fire(5, ok);
    @(negedge clk);
    n_cmp++; if (inst_valid !== 1'b0) begin n_fail++; $display("FAIL basic_latency: inst_valid=%b required 0", inst_valid); end
    @(negedge clk);
    n_cmp++; if (inst_valid !== 1'b1 || inst !== 32'h0010_0093 || inst_pc !== RST_PC)
      begin n_fail++; $display("FAIL basic_first: got v=%b inst %h pc %h required 1 00100093 %h", inst_valid, inst, inst_pc, RST_PC); end
    n_cmp++; if (imem_req_valid !== 1'b1 || imem_addr !== RST_PC + 64'd4)
      begin n_fail++; $display("FAIL basic_next_req: got v=%b addr %h required 1 %h", imem_req_valid, imem_addr, RST_PC + 64'd4); end
  endtask

  task automatic test_backpressure();
    bit ok;
    do_reset();
    imem_req_ready = 1;
    repeat (10) @(negedge clk);
    n_cmp++; if (inst_valid !== 1'b1 || inst_pc !== RST_PC || imem_req_valid !== 1'b0)
      begin n_fail++; $display("FAIL bp_full: got v=%b pc %h req=%b required 1 %h 0", inst_valid, inst_pc, imem_req_valid, RST_PC); end
    tick(); inst_ready = 1;
    @(negedge clk);
    n_cmp++; if (inst_pc !== RST_PC || imem_req_valid !== 1'b0)
      begin n_fail++; $display("FAIL bp_drain0: got pc %h req=%b required %h 0", inst_pc, imem_req_valid, RST_PC); end
    @(negedge clk);
    n_cmp++; if (inst_valid !== 1'b1 || inst_pc !== RST_PC + 64'd4)
      begin n_fail++; $display("FAIL bp_drain1: got v=%b pc %h required 1 %h", inst_valid, inst_pc, RST_PC + 64'd4); end
    n_cmp++; if (imem_req_valid !== 1'b1 || imem_addr !== RST_PC + 64'd8)
      begin n_fail++; $display("FAIL bp_resume: got v=%b addr %h required 1 %h", imem_req_valid, imem_addr, RST_PC + 64'd8); end
  endtask

  task automatic test_redirect_wait();
    bit ok;
    do_reset();
    lat_lo = 3; lat_hi = 3; imem_req_ready = 1; inst_ready = 1;
    wait_fire(5, ok);
    tick(); redirect_valid = 1; redirect_pc = 64'h8000_0103;
    tick(); redirect_valid = 0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      n_cmp++; if (inst_valid !== 1'b0 || imem_req_valid !== 1'b0)
        begin n_fail++; $display("FAIL rw_drop%0d: got v=%b req=%b required 0 0", i, inst_valid, imem_req_valid); end
    end
    @(negedge clk);
    n_cmp++; if (inst_valid !== 1'b0 || imem_req_valid !== 1'b1 || imem_addr !== 64'h8000_0100)
      begin n_fail++; $display("FAIL rw_target: got v=%b req=%b addr %h required 0 1 80000100", inst_valid, imem_req_valid, imem_addr); end
    ok = 0;
    for (int i = 0; i < 8 && !ok; i++) begin @(negedge clk); ok = inst_valid; end
    n_cmp++; if (!ok || inst_pc !== 64'h8000_0100)
      begin n_fail++; $display("FAIL rw_first_inst: got v=%b pc %h required 1 80000100", ok, inst_pc); end
  endtask

  task automatic test_redirect_rsp_pop();
    bit ok;
    do_reset();
    imem_req_ready = 1;
    wait_fire(5, ok);
    wait_fire(5, ok);
    tick(); redirect_valid = 1; redirect_pc = 64'h8000_1000; inst_ready = 1;
    @(negedge clk);
    n_cmp++; if (imem_rsp_valid !== 1'b1 || inst_valid !== 1'b1)
      begin n_fail++; $display("FAIL rrp_setup: got rsp=%b v=%b required 1 1", imem_rsp_valid, inst_valid); end
    tick(); redirect_valid = 0;
    @(negedge clk);
    n_cmp++; if (inst_valid !== 1'b0 || imem_req_valid !== 1'b1 || imem_addr !== 64'h8000_1000)
      begin n_fail++; $display("FAIL rrp_after: got v=%b req=%b addr %h required 0 1 80001000", inst_valid, imem_req_valid, imem_addr); end
  endtask

  task automatic test_reset_midreq();
    bit ok;
    do_reset();
    lat_lo = 4; lat_hi = 4; imem_req_ready = 1; inst_ready = 1;
    wait_fire(5, ok);
    tick(); rst = 0; imem_req_ready = 0;
    #1;
    n_cmp++; if (imem_addr !== RST_PC || inst_valid !== 1'b0 || imem_req_valid !== 1'b0)
      begin n_fail++; $display("FAIL mid_reset: got addr %h v=%b req=%b required %h 0 0", imem_addr, inst_valid, imem_req_valid, RST_PC); end
    tick(); rst = 1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      n_cmp++; if (inst_valid !== 1'b0) begin n_fail++; $display("FAIL late_rsp%0d: inst_valid=%b required 0", i, inst_valid); end
    end
    tick(); imem_req_ready = 1;
    wait_fire(5, ok);
    n_cmp++; if (imem_addr !== RST_PC) begin n_fail++; $display("FAIL mid_restart: got %h required %h", imem_addr, RST_PC); end
  endtask

  task automatic test_random();
    int p0;
    bit pr;
    do_reset();
    lat_lo = 1; lat_hi = 4; p0 = n_pop; pr = 0;
    for (int i = 0; i < 600; i++) begin
      tick();
      imem_req_ready = $urandom_range(0, 3) != 0;
      inst_ready = $urandom_range(0, 2) != 0;
      redirect_valid = !pr && $urandom_range(0, 15) == 0;
      redirect_pc = {$urandom, $urandom};
      pr = redirect_valid;
    end
    tick(); redirect_valid = 0; imem_req_ready = 0; inst_ready = 0;
    @(negedge clk);
    n_cmp++; if (n_pop - p0 < 20) begin n_fail++; $display("FAIL random_progress: %0d pops required at least 20", n_pop - p0); end
  endtask

`ifdef YSYX_22050039_IFU_PERF_EN
  task automatic test_perf();
    bit ok;
    do_reset();
    lat_lo = 2; lat_hi = 2; imem_req_ready = 1; inst_ready = 1;
    for (int i = 0; i < 6; i++) wait_fire(8, ok);
    tick(); redirect_valid = 1; redirect_pc = 64'h8000_2000; imem_req_ready = 0;
    tick(); redirect_valid = 0;
    repeat (4) @(negedge clk);
    n_cmp++; if (perf_fetch_cnt !== 32'd5) begin n_fail++; $display("FAIL perf_fetch: got %0d required 5", perf_fetch_cnt); end
    n_cmp++; if (perf_drop_cnt !== 32'd1) begin n_fail++; $display("FAIL perf_drop: got %0d required 1", perf_drop_cnt); end
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_redirect_wait();
    test_redirect_rsp_pop();
    test_reset_midreq();
    test_random();
`ifdef YSYX_22050039_IFU_PERF_EN
    test_perf();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule

// File: doc/ysyx_22050039_ifu_fetch.md
# ysyx_22050039_ifu_fetch

Instruction fetch stage of the ysyx_22050039 RISC-V core, sitting directly upstream of the instruction decode stage. It holds the program counter and issues one instruction-memory read at a time. Returned instructions are buffered in a small FIFO and handed to decode, tagged with their PC, through a valid/ready handshake. A redirect from execute (jal/jalr/branch) reloads the PC, flushes the FIFO and discards any stale in-flight response.

## Interface
- XLEN, 64, address/PC width
- INST_LEN, 32, instruction width
- RESET_PC, 64'h8000_0000, PC value after reset
- DEPTH, 2, instruction FIFO entries (power of two, ≥2)

Ports (name, direction, width, meaning):
- clk  in  1  single clock; all state updates on its rising edge
- rst  in  1  asynchronous, active-low reset
- imem_req_valid  out  1  read request valid
- imem_req_ready  in  1  memory accepts request
- imem_addr  out  XLEN  request address; equals PC
- imem_rsp_valid  in  1  read data valid; at most one response per accepted request, never in the same cycle as the acceptance
- imem_rsp_data  in  INST_LEN  fetched instruction
- inst_valid  out  1  FIFO head valid
- inst_ready  in  1  decode consumes head
- inst  out  INST_LEN  head instruction
- inst_pc  out  XLEN  PC of head instruction
- redirect_valid  in  1  control-flow redirect, single-cycle pulse
- redirect_pc  in  XLEN  redirect target; bits [1:0] are ignored and treated as 0

## Operation
- Registers:
  - pc: reset RESET_PC
  - fetch_pc: PC of the outstanding request
  - state: reset REQ
  - FIFO: count 0, head/tail 0, entry storage 0
- States:
  - REQ: imem_req_valid = rst && !full && !redirect_valid. On a handshake (valid && ready): fetch_pc<=pc, pc<=pc+4 (modulo 2^XLEN), go to WAIT.
  - WAIT: on rsp_valid with no redirect, push {rsp_data, fetch_pc} and go to REQ.
  - DROP: an outstanding response must be discarded. On rsp_valid, drop the data and go to REQ.
- Redirect handling:
  - In any state, redirect: pc<=redirect_pc & ~3, FIFO flushed (count<=0). A concurrent pop or push is cancelled.
  - Redirect in REQ: stay in REQ; no request is issued that cycle.
  - Redirect in WAIT without rsp_valid: go to DROP.
  - Redirect in WAIT with rsp_valid: discard the response, go to REQ.
  - Redirect in DROP: update pc, stay in DROP.
- Never more than one request outstanding.
- FIFO:
  - Issue only when not full. count cannot overflow because the single in-flight response lands while count ≤ DEPTH-1.
  - Push and pop in the same cycle leave count unchanged.
  - Head/tail pointers wrap modulo DEPTH.
- inst_valid = (count != 0). inst/inst_pc show the head entry; they are don't-care when inst_valid=0.
- Pop happens when inst_valid && inst_ready && !redirect_valid.
- Async reset mid-request: all state returns to reset values immediately. A memory response arriving after reset release while in REQ is ignored.

## Timing
- Reset values: imem_req_valid=0 while rst=0, imem_addr=RESET_PC, inst_valid=0, inst=0, inst_pc=0.
- Request accepted at cycle T, response at T+k (k≥1): inst_valid=1 at T+k+1 (registered FIFO).
- With k=1 and inst_ready held high, throughput is one instruction per 2 cycles.
- Redirect at cycle T: inst_valid=0 at T+1. The first request to the new target is issued at T+1 from REQ, or after the stale response is dropped from DROP.
- Outputs never depend combinationally on imem_rsp_*. imem_req_valid depends combinationally on redirect_valid.

## Configuration
- YSYX_22050039_IFU_PERF_EN defined:
  - Adds outputs perf_fetch_cnt (out, 32) and perf_drop_cnt (out, 32), both reset to 0.
  - perf_fetch_cnt increments on every FIFO push.
  - perf_drop_cnt increments on every response discarded in DROP or WAIT-with-redirect.
  - Both counters wrap at 2^32.
- Undefined: the ports and counters are absent; the remaining behaviour is identical.

## Test plan
- Reset release, memory ready=1 with 1-cycle latency returning 0x00100093, inst_ready=1 -> first request addr 0x8000_0000; inst=0x00100093, inst_pc=0x8000_0000 two cycles after acceptance; next request addr 0x8000_0004.
- inst_ready=0 with DEPTH=2 -> exactly two instructions buffered (pcs 0x..00, 0x..04), then imem_req_valid=0. Raising inst_ready drains them in order and fetching resumes at 0x..08.
- Redirect to 0x8000_0103 while in WAIT, response delayed 3 cycles -> response discarded, inst_valid stays 0, next request addr 0x8000_0100.
- Redirect in the same cycle as rsp_valid and an inst pop -> response dropped, FIFO empty next cycle, request to the target issued the following cycle.
- rst driven low while a request is outstanding, then released -> imem_addr=0x8000_0000, inst_valid=0, a late rsp_valid pulse produces no FIFO push.
- With YSYX_22050039_IFU_PERF_EN: 5 fetches plus 1 redirect during WAIT -> perf_fetch_cnt=5, perf_drop_cnt=1.
